// File: rtl/io_pkg.sv
// Shared definitions for the IO pulse sequencer.
// State encoding and channel count.
package io_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/io_down_counter.sv
// Loadable down counter with zero flag.
// Holds at zero; load wins over enable.
module io_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/io_pulse_seq.sv
// Timed one-hot pulse train sequencer feeding io_priority.
// One command at a time; abort/rst return to IDLE at once.
module io_pulse_seq
  import io_pkg::*;
#(
  parameter int CW = 16,
  parameter int RW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_chan,
  input  logic [CW-1:0]     cmd_delay,
  input  logic [CW-1:0]     cmd_width,
  input  logic [RW-1:0]     cmd_count,
  input  logic              abort,
  output logic [NUM_CH-1:0] pulse,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e state, nstate;

  logic [1:0]        chan_q, chan_n;
  logic [CW-1:0]     delay_q, width_q, ph_din;
  logic [RW-1:0]     rp_din;
  logic              ph_load, ph_en, ph_zero;
  logic              rp_load, rp_en, rp_zero;
  logic              accept, illegal;
  logic              done_n, err_n;
  logic [NUM_CH-1:0] pulse_n;

  io_down_counter #(.W(CW)) u_phase (
    .clk  (clk),
    .rst  (rst),
    .load (ph_load),
    .en   (ph_en),
    .din  (ph_din),
    .zero (ph_zero)
  );

  io_down_counter #(.W(RW)) u_repeat (
    .clk  (clk),
    .rst  (rst),
    .load (rp_load),
    .en   (rp_en),
    .din  (rp_din),
    .zero (rp_zero)
  );

  assign cmd_ready = (state == IDLE);
  assign illegal   = (cmd_chan >= 2'(NUM_CH))
                   || (cmd_width == '0);

  always_comb begin
    nstate  = state;
    ph_load = 1'b0;
    ph_en   = 1'b0;
    ph_din  = '0;
    rp_load = 1'b0;
    rp_en   = 1'b0;
    rp_din  = '0;
    accept  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && illegal) begin
          err_n = 1'b1;
        end else if (cmd_valid) begin
          accept  = 1'b1;
          ph_load = 1'b1;
          rp_load = 1'b1;
          if (cmd_count != '0) rp_din = cmd_count - RW'(1);
          if (cmd_delay == '0) begin
            nstate = PULSE;
            ph_din = cmd_width - CW'(1);
          end else begin
            nstate = DELAY;
            ph_din = cmd_delay - CW'(1);
          end
        end
      end
      DELAY, GAP: begin
        if (ph_zero) begin
          nstate  = PULSE;
          ph_load = 1'b1;
          ph_din  = width_q - CW'(1);
        end else begin
          ph_en = 1'b1;
        end
      end
      PULSE: begin
        if (!ph_zero) begin
          ph_en = 1'b1;
        end else if (rp_zero) begin
          nstate = IDLE;
          done_n = 1'b1;
        end else begin
          rp_en   = 1'b1;
          ph_load = 1'b1;
          // Zero gap chains straight into the next pulse.
          if (delay_q == '0) begin
            nstate = PULSE;
            ph_din = width_q - CW'(1);
          end else begin
            nstate = GAP;
            ph_din = delay_q - CW'(1);
          end
        end
      end
      default: nstate = IDLE;
    endcase
    if (abort && state != IDLE) begin
      nstate  = IDLE;
      ph_load = 1'b0;
      ph_en   = 1'b0;
      rp_en   = 1'b0;
      done_n  = 1'b0;
    end
  end

  assign chan_n  = accept ? cmd_chan : chan_q;
  assign pulse_n = (nstate == PULSE)
                 ? (NUM_CH'(1) << chan_n) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      chan_q  <= '0;
      delay_q <= '0;
      width_q <= '0;
      pulse   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        chan_q  <= cmd_chan;
        delay_q <= cmd_delay;
        width_q <= cmd_width;
      end
      pulse <= pulse_n;
      busy  <= (nstate != IDLE);
      done  <= done_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_io_pulse_seq.sv
// Scoreboard bench for io_pulse_seq: per-cycle expected
// outputs are derived from the command timing rules.
module tb_io_pulse_seq;

  localparam int CW = 16;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    cmd_chan = '0;
  logic [CW-1:0] cmd_delay = '0;
  logic [CW-1:0] cmd_width = '0;
  logic [RW-1:0] cmd_count = '0;
  logic          cmd_ready, busy, done, err;
  logic [2:0]    pulse;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int free_cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] pulse;
    logic       busy;
    logic       done;
    logic       err;
  } rec_t;

  rec_t q[$];

  io_pulse_seq #(.CW(CW), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_chan  (cmd_chan),
    .cmd_delay (cmd_delay),
    .cmd_width (cmd_width),
    .cmd_count (cmd_count),
    .abort     (abort),
    .pulse     (pulse),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cycles without a queued record must be idle.
  always @(negedge clk) begin
    rec_t e;
    logic [6:0] act, expv;
    if (mon_en) begin
      e = '{cyc, 3'b000, 1'b0, 1'b0, 1'b0};
      if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
      act  = {pulse, busy, done, err, cmd_ready};
      expv = {e.pulse, e.busy, e.done, e.err, ~e.busy};
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL outputs cyc=%0d {pulse,busy,done,err,ready} got=%b want=%b",
                 cyc, act, expv);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    cmd_valid = 1'($urandom);
    cmd_chan  = 2'($urandom);
    cmd_delay = CW'($urandom);
    cmd_width = CW'($urandom);
    cmd_count = RW'($urandom);
  endtask

  // kill: 0 none, 1 abort, 2 reset; koff<1 picks a random busy cycle.
  task automatic run(input int c, input int d, input int w,
                     input int n, input int kill, input int koff,
                     input int gap, input bit idle_abort);
    int t0, ne, len, o, r, a;
    logic [2:0] p;
    while (cyc < free_cyc) begin
      junk();
      tick();
    end
    repeat (gap) begin
      cmd_valid = 1'b0;
      abort = 1'($urandom);
      tick();
    end
    t0 = cyc;
    cmd_valid = 1'b1;
    cmd_chan  = 2'(c);
    cmd_delay = CW'(d);
    cmd_width = CW'(w);
    cmd_count = RW'(n);
    abort     = idle_abort;
    if (c == 3 || w == 0) begin
      q.push_back('{t0 + 1, 3'b000, 1'b0, 1'b0, 1'b1});
      free_cyc = t0 + 1;
      tick();
      cmd_valid = 1'b0;
      abort = 1'b0;
      return;
    end
    ne  = (n == 0) ? 1 : n;
    len = d + ne * w + (ne - 1) * d;
    for (int t = 1; t <= len; t++) begin
      o = t - 1;
      p = 3'b000;
      if (o >= d) begin
        r = (o - d) % (w + d);
        if (r < w) p = 3'b001 << c;
      end
      q.push_back('{t0 + t, p, 1'b1, 1'b0, 1'b0});
    end
    q.push_back('{t0 + len + 1, 3'b000, 1'b0, 1'b1, 1'b0});
    free_cyc = t0 + len + 1;
    tick();
    cmd_valid = 1'b0;
    abort = 1'b0;
    if (kill != 0) begin
      a = t0 + ((koff >= 1) ? koff : $urandom_range(1, len));
      while (cyc < a) begin
        junk();
        tick();
      end
      if (kill == 1) abort = 1'b1;
      else rst = 1'b1;
      while (q.size() > 0 && q[q.size() - 1].cyc > a)
        void'(q.pop_back());
      free_cyc = a + 1;
      tick();
      abort = 1'b0;
      rst = 1'b0;
    end
  endtask

  initial begin
    int c, d, w, n, k;
    repeat (3) tick();
    rst = 1'b0;
    free_cyc = cyc;
    mon_en = 1'b1;
    tick();
    // reset mid-pulse
    run(0, 1, 5, 2, 2, 4, 0, 1'b0);
    // single pulse
    run(1, 3, 4, 1, 0, 0, 0, 1'b0);
    // pulse train
    run(2, 2, 1, 3, 0, 0, 0, 1'b0);
    // zero delay, back-to-back pulses
    run(0, 0, 2, 2, 0, 0, 1, 1'b0);
    // illegal channel and zero width
    run(3, 2, 2, 1, 0, 0, 0, 1'b0);
    run(1, 2, 0, 1, 0, 0, 0, 1'b0);
    // abort inside the first gap, then immediate new command
    run(1, 3, 2, 4, 1, 7, 0, 1'b0);
    run(2, 1, 1, 2, 0, 0, 0, 1'b0);
    // abort in idle alongside a command is a no-op
    run(0, 2, 3, 0, 0, 0, 0, 1'b1);
    // full repeat count and full delay
    run(2, 0, 1, 255, 0, 0, 0, 1'b0);
    run(1, 65535, 1, 1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      d = $urandom_range(0, 4);
      w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      n = $urandom_range(0, 4);
      k = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      run(c, d, w, n, k, 0, $urandom_range(0, 2),
          1'($urandom_range(0, 7) == 0));
    end
    while (cyc < free_cyc + 3) begin
      cmd_valid = 1'b0;
      tick();
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
